updown_count_monitor: RTL and testbench
=======================================

UPDOWN_COUNT_MONITOR -- requirements
Module: updown_count_monitor

Interface
REQ-001 Parameter ERR_LIMIT, default 4, meaning: error count (1..255) at which fault asserts.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset; acts immediately on assertion, independent of clk.
REQ-004 count  input  3  registered count from the 3-bit up/down counter stage.
REQ-005 mode  input  1  direction driven to that counter (1 = up, 0 = down).
REQ-006 en  input  1  sample-valid; high on cycles where count/mode are to be checked.
REQ-007 clr  input  1  synchronous clear of monitor state and statistics.
REQ-008 wrap_up  output  1  one-cycle pulse: legal 7->0 transition in up mode.
REQ-009 wrap_dn  output  1  one-cycle pulse: legal 0->7 transition in down mode.
REQ-010 dir_chg  output  1  one-cycle pulse: mode differs from previous sampled mode.
REQ-011 step_err  output  1  one-cycle pulse: illegal count step detected.
REQ-012 err_cnt  output  8  saturating count of step errors.
REQ-013 lap_cnt  output  8  net laps: +1 per wrap_up, -1 per wrap_dn, modulo 256.
REQ-014 fault  output  1  sticky flag; high once err_cnt >= ERR_LIMIT.

Function
REQ-015 All outputs SHALL be registered; pulses appear the cycle after the sampling edge.
REQ-016 States SHALL be IDLE (no reference sample held), TRACK, FAULT.
REQ-017 IDLE: on en=1, capture prev_count=count and prev_mode=mode, go to TRACK; no checks, no pulses.
REQ-018 TRACK/FAULT: on en=1, expected = prev_mode ? prev_count+1 : prev_count-1, computed modulo 8 (3-bit wrap).
REQ-019 count == expected SHALL be legal; count != expected SHALL pulse step_err and increment err_cnt.
REQ-020 err_cnt SHALL saturate at 255; no wrap to 0.
REQ-021 wrap_up SHALL pulse only for a legal step with prev_count=7, prev_mode=1, count=0; wrap_dn only for a legal step with prev_count=0, prev_mode=0, count=7.
REQ-022 lap_cnt SHALL increment on wrap_up and decrement on wrap_dn, wrapping modulo 256 in both directions.
REQ-023 dir_chg SHALL pulse when en=1 in TRACK/FAULT and mode != prev_mode, independent of step legality.
REQ-024 On every en=1 sample in TRACK/FAULT, prev_count/prev_mode SHALL update to the current inputs, including after an error; resync is implicit.
REQ-025 en=0: hold all state and counters; all pulses low.
REQ-026 TRACK->FAULT SHALL occur on the edge where the updated err_cnt first reaches ERR_LIMIT; fault rises with that step_err pulse.
REQ-027 FAULT SHALL continue all checking, pulses and counting; it exits only on clr or rst.
REQ-028 clr=1 SHALL go to IDLE and zero err_cnt, lap_cnt, fault and all pulses; clr takes priority over a simultaneous en.
REQ-029 The first en sample after clr or reset SHALL never produce step_err, even if the count differs from the pre-clear history.

Reset
REQ-030 rst=0 SHALL force state IDLE and set all outputs, err_cnt, lap_cnt, prev_count and prev_mode to 0, asynchronously.
REQ-031 Release of rst SHALL take effect at the next posedge clk; the first en sample is treated per REQ-017.
REQ-032 Reset mid-operation SHALL discard the held reference sample and the statistics; no pulse is generated for the interrupted step.

Verification
REQ-033 Reset release, en=1, mode=1, count 5,6,7,0,1 -> no step_err; one wrap_up one cycle after the 0 sample; lap_cnt=1.
REQ-034 mode=0, count 1,0,7,6 -> one wrap_dn; lap_cnt steps 0->255; err_cnt=0.
REQ-035 mode=1, count 2,3,5 -> step_err pulse on the 5 sample; err_cnt=1; next step 5->6 is legal.
REQ-036 Four illegal steps (ERR_LIMIT=4) -> fault high with the 4th step_err; clr=1 together with en=1 -> err_cnt=0, fault=0, no pulse, state IDLE.
REQ-037 mode 1 then 0 with count 3,4,3 -> dir_chg pulse on the second sample; no step_err because the step 4->3 uses prev_mode=0.
REQ-038 rst asserted between clock edges mid-sequence -> outputs 0 immediately; after release, count=6 as the first sample -> no step_err.

Source files
------------

// File: rtl/updown_count_monitor_if.sv
// Bus bundle for updown_count_monitor.
//   count/mode : sampled counter value and the direction driven to that counter
//   en         : sample-valid
//   clr        : synchronous clear of monitor state and statistics
//   wrap_up, wrap_dn, dir_chg, step_err : one-cycle event pulses
//   err_cnt    : saturating step-error count
//   lap_cnt    : net laps, modulo 256
//   fault      : sticky error-limit flag
// master = stimulus side, slave = monitor side.
interface updown_count_monitor_if;
  logic [2:0] count;
  logic       mode;
  logic       en;
  logic       clr;
  logic       wrap_up;
  logic       wrap_dn;
  logic       dir_chg;
  logic       step_err;
  logic [7:0] err_cnt;
  logic [7:0] lap_cnt;
  logic       fault;

  modport master (
    output count, mode, en, clr,
    input  wrap_up, wrap_dn, dir_chg, step_err, err_cnt, lap_cnt, fault
  );

  modport slave (
    input  count, mode, en, clr,
    output wrap_up, wrap_dn, dir_chg, step_err, err_cnt, lap_cnt, fault
  );
endinterface

// File: rtl/updown_count_monitor.sv
// Checks the step sequence of a 3-bit up/down counter.
// Each valid sample is compared against the previous sample advanced by one
// in the previous direction (mod 8). Wraps, direction changes and illegal
// steps are flagged with registered one-cycle pulses; errors and net laps
// are counted, and a sticky fault is raised once the error count reaches
// ERR_LIMIT.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : updown_count_monitor_if.slave (inputs count/mode/en/clr, all outputs)
module updown_count_monitor #(
  parameter int ERR_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  updown_count_monitor_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(ERR_LIMIT);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  state_t     state;
  logic [2:0] prev_count;
  logic       prev_mode;

  logic       wrap_up_q, wrap_dn_q, dir_chg_q, step_err_q, fault_q;
  logic [7:0] err_cnt_q, lap_cnt_q;

  logic [2:0] expected;
  logic       legal;
  logic [7:0] err_nx;

  // Expected next count wraps naturally in 3 bits.
  always_comb begin
    expected = prev_mode ? prev_count + 3'd1 : prev_count - 3'd1;
    legal    = (bus.count == expected);
    err_nx   = (!legal && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev_count <= 3'd0;
      prev_mode  <= 1'b0;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      dir_chg_q  <= 1'b0;
      step_err_q <= 1'b0;
      fault_q    <= 1'b0;
      err_cnt_q  <= 8'd0;
      lap_cnt_q  <= 8'd0;
    end else begin
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      dir_chg_q  <= 1'b0;
      step_err_q <= 1'b0;
      if (bus.clr) begin
        state      <= IDLE;
        prev_count <= 3'd0;
        prev_mode  <= 1'b0;
        fault_q    <= 1'b0;
        err_cnt_q  <= 8'd0;
        lap_cnt_q  <= 8'd0;
      end else if (bus.en) begin
        // Reference always follows the latest sample, so an error resyncs.
        prev_count <= bus.count;
        prev_mode  <= bus.mode;
        if (state == IDLE) begin
          state <= TRACK;
        end else begin
          step_err_q <= !legal;
          err_cnt_q  <= err_nx;
          dir_chg_q  <= (bus.mode != prev_mode);
          wrap_up_q  <= legal &&  prev_mode && prev_count == 3'd7 && bus.count == 3'd0;
          wrap_dn_q  <= legal && !prev_mode && prev_count == 3'd0 && bus.count == 3'd7;
          if (legal && prev_mode && prev_count == 3'd7)
            lap_cnt_q <= lap_cnt_q + 8'd1;
          else if (legal && !prev_mode && prev_count == 3'd0)
            lap_cnt_q <= lap_cnt_q - 8'd1;
          // Fault rises together with the step_err that reaches the limit.
          if (state == TRACK && err_nx >= LIMIT) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.wrap_up  = wrap_up_q;
  assign bus.wrap_dn  = wrap_dn_q;
  assign bus.dir_chg  = dir_chg_q;
  assign bus.step_err = step_err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.lap_cnt  = lap_cnt_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
module tb_updown_count_monitor;

  typedef struct packed {
    logic       wu;
    logic       wd;
    logic       dc;
    logic       se;
    logic [7:0] err;
    logic [7:0] lap;
    logic       flt;
  } outs_t;

  typedef struct {
    string      name;
    logic       en;
    logic       clr;
    logic       mode;
    logic [2:0] cnt;
    outs_t      exp;
  } vec_t;

  logic clk;
  logic rst;
  updown_count_monitor_if ifc();

  updown_count_monitor #(.ERR_LIMIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  vec_t  vecs[$];
  outs_t sb_exp[$];
  string sb_name[$];

  function automatic outs_t mk(logic wu, logic wd, logic dc, logic se,
                               logic [7:0] err, logic [7:0] lap, logic flt);
    outs_t o;
    o.wu = wu; o.wd = wd; o.dc = dc; o.se = se;
    o.err = err; o.lap = lap; o.flt = flt;
    return o;
  endfunction

  function automatic void add(string n, logic en, logic clr, logic mode,
                              logic [2:0] c, outs_t e);
    vec_t v;
    v.name = n; v.en = en; v.clr = clr; v.mode = mode; v.cnt = c; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic outs_t dut_outs();
    return mk(ifc.wrap_up, ifc.wrap_dn, ifc.dir_chg, ifc.step_err,
              ifc.err_cnt, ifc.lap_cnt, ifc.fault);
  endfunction

  task automatic check(string n, outs_t act, outs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got wu=%b wd=%b dc=%b se=%b err=%0d lap=%0d flt=%b, want wu=%b wd=%b dc=%b se=%b err=%0d lap=%0d flt=%b",
               n, act.wu, act.wd, act.dc, act.se, act.err, act.lap, act.flt,
               exp.wu, exp.wd, exp.dc, exp.se, exp.err, exp.lap, exp.flt);
    end
  endtask

  // Drive one sample, push its expectation, and compare after the edge.
  task automatic apply(string n, logic en, logic clr, logic mode,
                       logic [2:0] c, outs_t e);
    ifc.en = en; ifc.clr = clr; ifc.mode = mode; ifc.count = c;
    sb_exp.push_back(e);
    sb_name.push_back(n);
    @(posedge clk);
    #1;
    check(sb_name.pop_front(), dut_outs(), sb_exp.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Up run with a 7->0 wrap.
    add("up5_capture", 1, 0, 1, 3'd5, mk(0,0,0,0, 0,  0,0));
    add("up6",         1, 0, 1, 3'd6, mk(0,0,0,0, 0,  0,0));
    add("up7",         1, 0, 1, 3'd7, mk(0,0,0,0, 0,  0,0));
    add("up0_wrap",    1, 0, 1, 3'd0, mk(1,0,0,0, 0,  1,0));
    add("up1",         1, 0, 1, 3'd1, mk(0,0,0,0, 0,  1,0));
    // Down run with a 0->7 wrap, lap 0 -> 255.
    add("clr_a",       1, 1, 0, 3'd1, mk(0,0,0,0, 0,  0,0));
    add("dn1_capture", 1, 0, 0, 3'd1, mk(0,0,0,0, 0,  0,0));
    add("dn0",         1, 0, 0, 3'd0, mk(0,0,0,0, 0,  0,0));
    add("dn7_wrap",    1, 0, 0, 3'd7, mk(0,1,0,0, 0,255,0));
    add("dn6",         1, 0, 0, 3'd6, mk(0,0,0,0, 0,255,0));
    // Illegal step and resync.
    add("clr_b",       1, 1, 1, 3'd2, mk(0,0,0,0, 0,  0,0));
    add("e2_capture",  1, 0, 1, 3'd2, mk(0,0,0,0, 0,  0,0));
    add("e3",          1, 0, 1, 3'd3, mk(0,0,0,0, 0,  0,0));
    add("e5_err",      1, 0, 1, 3'd5, mk(0,0,0,1, 1,  0,0));
    add("e6_resync",   1, 0, 1, 3'd6, mk(0,0,0,0, 1,  0,0));
    // Errors up to the limit, fault, then clear with en.
    add("err2",        1, 0, 1, 3'd0, mk(0,0,0,1, 2,  0,0));
    add("err3",        1, 0, 1, 3'd0, mk(0,0,0,1, 3,  0,0));
    add("err4_fault",  1, 0, 1, 3'd0, mk(0,0,0,1, 4,  0,1));
    add("fault_legal", 1, 0, 1, 3'd1, mk(0,0,0,0, 4,  0,1));
    add("clr_with_en", 1, 1, 1, 3'd5, mk(0,0,0,0, 0,  0,0));
    add("post_clr_cap",1, 0, 1, 3'd3, mk(0,0,0,0, 0,  0,0));
    add("post_clr_4",  1, 0, 1, 3'd4, mk(0,0,0,0, 0,  0,0));
    // en=0 holds the reference.
    add("en0_hold",    0, 0, 0, 3'd7, mk(0,0,0,0, 0,  0,0));
    add("after_hold5", 1, 0, 1, 3'd5, mk(0,0,0,0, 0,  0,0));
    // Direction change.
    add("clr_c",       1, 1, 1, 3'd0, mk(0,0,0,0, 0,  0,0));
    add("dc3_capture", 1, 0, 1, 3'd3, mk(0,0,0,0, 0,  0,0));
    add("dc4_chg",     1, 0, 0, 3'd4, mk(0,0,1,0, 0,  0,0));
    add("dc3_down",    1, 0, 0, 3'd3, mk(0,0,0,0, 0,  0,0));
    // Lap counter 255 -> 0.
    add("clr_d",       1, 1, 0, 3'd0, mk(0,0,0,0, 0,  0,0));
    add("lap0_capture",1, 0, 0, 3'd0, mk(0,0,0,0, 0,  0,0));
    add("lap7_dn",     1, 0, 0, 3'd7, mk(0,1,0,0, 0,255,0));
    add("lap6_turn",   1, 0, 1, 3'd6, mk(0,0,1,0, 0,255,0));
    add("lap7_up",     1, 0, 1, 3'd7, mk(0,0,0,0, 0,255,0));
    add("lap0_wrap",   1, 0, 1, 3'd0, mk(1,0,0,0, 0,  0,0));

    rst = 1'b0;
    ifc.en = 1'b1; ifc.clr = 1'b0; ifc.mode = 1'b1; ifc.count = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_outs(), mk(0,0,0,0, 0,0,0));
    ifc.en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].en, vecs[i].clr, vecs[i].mode, vecs[i].cnt, vecs[i].exp);

    // Saturation: repeated illegal steps, err_cnt stops at 255.
    apply("sat_clr",     1, 1, 1, 3'd0, mk(0,0,0,0, 0,0,0));
    apply("sat_capture", 1, 0, 1, 3'd0, mk(0,0,0,0, 0,0,0));
    for (int i = 1; i <= 260; i++) begin
      int e;
      e = (i > 255) ? 255 : i;
      apply("sat_err", 1, 0, 1, 3'd0, mk(0,0,0,1, 8'(e), 0, (i >= 4)));
    end

    // Asynchronous reset between edges.
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", dut_outs(), mk(0,0,0,0, 0,0,0));
    #1;
    rst = 1'b1;
    apply("rst_first6", 1, 0, 1, 3'd6, mk(0,0,0,0, 0,0,0));
    apply("rst_then7",  1, 0, 1, 3'd7, mk(0,0,0,0, 0,0,0));
    apply("rst_err",    1, 0, 1, 3'd2, mk(0,0,0,1, 1,0,0));

    if (sb_exp.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
